srpt_grant_sched: RTL and testbench
===================================

SRPT_GRANT_SCHED -- requirements
Module: srpt_grant_sched

Interface
REQ-001 SHALL have parameter MAX_OVERCOMMIT, default 8, meaning the number of concurrently granted RPC slots.
REQ-002 SHALL have parameter MAX_OVERCOMMIT_LOG2, default 3, meaning the slot index width.
REQ-003 SHALL have parameter RTT_PKTS, default 8, meaning the maximum grant window beyond received packets.
REQ-004 SHALL have parameter PACE_CYCLES, default 4, meaning the idle cycles enforced after each emitted grant (0 = none).
REQ-005 Ports, in order (one clock; reset is synchronous and active-high):
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- ap_ce  in  1  clock enable
- grant_in_empty_i  in  1  input FIFO empty
- grant_in_read_en_o  out  1  input pop strobe
- grant_in_data_i  in  51  SRPT entry {peer[50:37], rpc[36:23], recv[22:13], grantable[12:3], prio[2:0]}
- grant_out_full_i  in  1  output FIFO full
- grant_out_write_en_o  out  1  output push strobe
- grant_out_data_o  out  41  grant {peer[40:27], rpc[26:13], offset[12:3], prio[2:0]}
- active_count_o  out  MAX_OVERCOMMIT_LOG2+1  valid slot count
- drop_count_o  out  16  entries dropped for lack of a slot, saturating

Function
REQ-006 SHALL implement FSM states IDLE, LOOKUP, EMIT, PACE.
REQ-007 IDLE: when grant_in_empty_i=0, capture grant_in_data_i, assert grant_in_read_en_o for exactly one cycle, and enter LOOKUP; otherwise remain in IDLE.
REQ-008 LOOKUP SHALL last one cycle and compare captured {peer,rpc} against all valid slots; the lowest matching index wins.
REQ-009 A prio of SRPT_BLOCK (3'b001) SHALL clear the matched slot's valid bit, or act as a no-op on a miss, then return to IDLE.
REQ-010 A prio of SRPT_ACTIVE (3'b110) SHALL compute offset = recv + min(grantable, RTT_PKTS), 10-bit, saturating at 1023.
REQ-011 ACTIVE with grantable=0 SHALL free the matched slot (or no-op on a miss) and emit nothing.
REQ-012 ACTIVE hit: if offset > slot.granted, store offset and go to EMIT; otherwise go to IDLE.
REQ-013 ACTIVE miss: allocate the lowest free slot, set granted=offset, and go to EMIT; if no slot is free, increment drop_count_o (saturating at 0xFFFF) and go to IDLE.
REQ-014 All other prio codes SHALL be ignored (return to IDLE).
REQ-015 EMIT: when grant_out_full_i=0, drive grant_out_data_o = {peer, rpc, offset, slot index} and assert grant_out_write_en_o for one cycle, then enter PACE (or IDLE if PACE_CYCLES=0); when full, stall with no write.
REQ-016 PACE SHALL remain exactly PACE_CYCLES cycles and then enter IDLE; no input pop SHALL occur during PACE.
REQ-017 Minimum latency SHALL be: capture edge k, write_en high after edge k+2.
REQ-018 grant_out_data_o SHALL hold its last value when not writing.
REQ-019 active_count_o SHALL update the cycle after any slot allocation or free.
REQ-020 When ap_ce=0: FSM, slots, counters and data hold; both strobes deassert at the next edge; a stalled EMIT or PACE resumes when ap_ce returns.
REQ-021 A freed slot SHALL be reusable by the very next LOOKUP.

Reset
REQ-022 On ap_rst: state=IDLE, all slots invalid, slot granted fields 0, pace counter 0, both strobes 0, grant_out_data_o=0, active_count_o=0, drop_count_o=0.
REQ-023 Reset asserted mid-operation SHALL discard the captured entry and any pending emission; no strobe is asserted in the cycle after reset.

Structure
REQ-024 Entry/grant field ranges, the SRPT_* priority codes and the grant width SHALL live in shared package srpt_pkg.
REQ-025 The combinational CAM lookup plus lowest-free-slot encoder SHALL be sub-module srpt_slot_match.

Verification
REQ-026 New ACTIVE {peer 5, rpc 9, recv 1, grantable 20}: one write of {5, 9, offset 9, prio 0}; active_count=1.
REQ-027 Same RPC, recv 3, grantable 2 -> offset 5 (not greater than 9): no write. Then recv 10, grantable 12 -> write with offset 18.
REQ-028 Nine distinct ACTIVE RPCs: slots 0-7 are granted; the ninth gives drop_count=1 and no write. Then BLOCK on slot 3's RPC, then a new RPC -> granted with prio 3.
REQ-029 Two back-to-back entries with PACE_CYCLES=4: second write_en exactly 4 + 3 cycles after the first; grant_out_full_i high for 5 cycles delays the write by 5 cycles with data stable.
REQ-030 ap_rst pulsed one cycle after capture: no write, active_count=0, and the next entry allocates slot 0.

Source files
------------

// File: rtl/srpt_pkg.sv
// Shared definitions for the SRPT grant scheduler: entry/grant layouts,
// priority codes, FSM states and the grant offset arithmetic.
package srpt_pkg;

    localparam int PEER_W  = 14;
    localparam int RPC_W   = 14;
    localparam int CNT_W   = 10;
    localparam int PRIO_W  = 3;
    localparam int KEY_W   = PEER_W + RPC_W;
    localparam int ENTRY_W = PEER_W + RPC_W + CNT_W + CNT_W + PRIO_W;  // 51
    localparam int GRANT_W = PEER_W + RPC_W + CNT_W + PRIO_W;          // 41

    localparam logic [PRIO_W-1:0] SRPT_BLOCK  = 3'b001;
    localparam logic [PRIO_W-1:0] SRPT_ACTIVE = 3'b110;
    localparam logic [CNT_W-1:0]  OFFSET_MAX  = 10'd1023;

    // Input entry: {peer[50:37], rpc[36:23], recv[22:13], grantable[12:3], prio[2:0]}
    typedef struct packed {
        logic [PEER_W-1:0] peer;
        logic [RPC_W-1:0]  rpc;
        logic [CNT_W-1:0]  recv;
        logic [CNT_W-1:0]  grantable;
        logic [PRIO_W-1:0] prio;
    } srpt_entry_t;

    // Output grant: {peer[40:27], rpc[26:13], offset[12:3], prio[2:0]}
    typedef struct packed {
        logic [PEER_W-1:0] peer;
        logic [RPC_W-1:0]  rpc;
        logic [CNT_W-1:0]  offset;
        logic [PRIO_W-1:0] prio;
    } srpt_grant_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EMIT,
        ST_PACE
    } sched_state_t;

    // offset = recv + min(grantable, window), saturating at the 10-bit maximum
    function automatic logic [CNT_W-1:0] grant_offset(
        input logic [CNT_W-1:0] recv,
        input logic [CNT_W-1:0] grantable,
        input logic [CNT_W-1:0] window
    );
        logic [CNT_W-1:0] step;
        logic [CNT_W:0]   sum;
        step = (grantable < window) ? grantable : window;
        sum  = {1'b0, recv} + {1'b0, step};
        return sum[CNT_W] ? OFFSET_MAX : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/srpt_slot_match.sv
// Combinational CAM over the RPC slot table: lowest matching valid slot and
// lowest free slot.
module srpt_slot_match
    import srpt_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]       valid_i,
    input  logic [N*KEY_W-1:0] keys_i,
    input  logic [KEY_W-1:0]   key_i,
    output logic               hit_o,
    output logic [IDX_W-1:0]   hit_idx_o,
    output logic               free_o,
    output logic [IDX_W-1:0]   free_idx_o
);

    // Scan from the top down so the lowest index is the last, winning assignment
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a miss would infer a latch.
        hit_o      = 1'b0;
        hit_idx_o  = '0;
        free_o     = 1'b0;
        free_idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_i[i] && (keys_i[i*KEY_W +: KEY_W] == key_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
            if (!valid_i[i]) begin
                free_o     = 1'b1;
                free_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/srpt_grant_sched.sv
// SRPT grant scheduler: pops SRPT entries, tracks up to MAX_OVERCOMMIT granted
// RPCs in a slot table, and emits paced, monotonically increasing grants.
module srpt_grant_sched
    import srpt_pkg::*;
#(
    parameter int MAX_OVERCOMMIT      = 8,
    parameter int MAX_OVERCOMMIT_LOG2 = 3,
    parameter int RTT_PKTS            = 8,
    parameter int PACE_CYCLES         = 4
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_ce,
    input  logic                         grant_in_empty_i,
    output logic                         grant_in_read_en_o,
    input  logic [ENTRY_W-1:0]           grant_in_data_i,
    input  logic                         grant_out_full_i,
    output logic                         grant_out_write_en_o,
    output logic [GRANT_W-1:0]           grant_out_data_o,
    output logic [MAX_OVERCOMMIT_LOG2:0] active_count_o,
    output logic [15:0]                  drop_count_o
);

    localparam int IDX_W  = MAX_OVERCOMMIT_LOG2;
    localparam int PACE_W = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WINDOW = CNT_W'(RTT_PKTS);

    sched_state_t              state_q, state_d;
    srpt_entry_t               entry_q, entry_d;
    logic [PACE_W-1:0]         pace_q, pace_d;
    logic                      pop_q, pop_d;
    logic                      push_q, push_d;
    logic [GRANT_W-1:0]        data_q, data_d;
    logic [CNT_W-1:0]          emit_off_q, emit_off_d;
    logic [IDX_W-1:0]          emit_idx_q, emit_idx_d;
    logic [MAX_OVERCOMMIT_LOG2:0] act_q, act_d;
    logic [15:0]               drop_q, drop_d;
    logic [MAX_OVERCOMMIT-1:0] valid_q, valid_d;
    logic [KEY_W-1:0]          key_q     [MAX_OVERCOMMIT];
    logic [KEY_W-1:0]          key_d     [MAX_OVERCOMMIT];
    logic [CNT_W-1:0]          granted_q [MAX_OVERCOMMIT];
    logic [CNT_W-1:0]          granted_d [MAX_OVERCOMMIT];

    logic [MAX_OVERCOMMIT*KEY_W-1:0] keys_flat;
    logic [KEY_W-1:0]          cur_key;
    logic                      hit, free;
    logic [IDX_W-1:0]          hit_idx, free_idx;
    logic [CNT_W-1:0]          offset;

    // Flatten the slot keys for the CAM and form the lookup key and offset
    always_comb begin
        for (int i = 0; i < MAX_OVERCOMMIT; i++) begin
            keys_flat[i*KEY_W +: KEY_W] = key_q[i];
        end
        cur_key = {entry_q.peer, entry_q.rpc};
        offset  = grant_offset(entry_q.recv, entry_q.grantable, WINDOW);
    end

    srpt_slot_match #(
        .N     (MAX_OVERCOMMIT),
        .IDX_W (IDX_W)
    ) u_match (
        .valid_i    (valid_q),
        .keys_i     (keys_flat),
        .key_i      (cur_key),
        .hit_o      (hit),
        .hit_idx_o  (hit_idx),
        .free_o     (free),
        .free_idx_o (free_idx)
    );

    // Next-state logic: FSM, slot table updates, strobes and counters
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        pace_d     = pace_q;
        data_d     = data_q;
        emit_off_d = emit_off_q;
        emit_idx_d = emit_idx_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        key_d      = key_q;
        granted_d  = granted_q;
        pop_d      = 1'b0;
        push_d     = 1'b0;

        if (ap_ce) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!grant_in_empty_i) begin
                        entry_d = srpt_entry_t'(grant_in_data_i);
                        pop_d   = 1'b1;
                        state_d = ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    state_d = ST_IDLE;
                    if (entry_q.prio == SRPT_BLOCK) begin
                        if (hit) valid_d[hit_idx] = 1'b0;
                    end else if (entry_q.prio == SRPT_ACTIVE) begin
                        if (entry_q.grantable == '0) begin
                            if (hit) valid_d[hit_idx] = 1'b0;
                        end else if (hit) begin
                            if (offset > granted_q[hit_idx]) begin
                                granted_d[hit_idx] = offset;
                                emit_off_d         = offset;
                                emit_idx_d         = hit_idx;
                                state_d            = ST_EMIT;
                            end
                        end else if (free) begin
                            valid_d[free_idx]   = 1'b1;
                            key_d[free_idx]     = cur_key;
                            granted_d[free_idx] = offset;
                            emit_off_d          = offset;
                            emit_idx_d          = free_idx;
                            state_d             = ST_EMIT;
                        end else if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (!grant_out_full_i) begin
                        push_d = 1'b1;
                        data_d = {entry_q.peer, entry_q.rpc, emit_off_q,
                                  PRIO_W'(emit_idx_q)};
                        if (PACE_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            pace_d  = PACE_W'(PACE_CYCLES - 1);
                            state_d = ST_PACE;
                        end
                    end
                end
                ST_PACE: begin
                    if (pace_q == '0) state_d = ST_IDLE;
                    else              pace_d  = pace_q - 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        act_d = '0;
        for (int i = 0; i < MAX_OVERCOMMIT; i++) begin
            act_d = act_d + {{MAX_OVERCOMMIT_LOG2{1'b0}}, valid_d[i]};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge ap_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            entry_q    <= '0;
            pace_q     <= '0;
            pop_q      <= 1'b0;
            push_q     <= 1'b0;
            data_q     <= '0;
            emit_off_q <= '0;
            emit_idx_q <= '0;
            act_q      <= '0;
            drop_q     <= '0;
            valid_q    <= '0;
            // NOTE: the slot table is small flop storage, so it is reset outright; no stale keys survive.
            for (int i = 0; i < MAX_OVERCOMMIT; i++) begin
                key_q[i]     <= '0;
                granted_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            pace_q     <= pace_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            data_q     <= data_d;
            emit_off_q <= emit_off_d;
            emit_idx_q <= emit_idx_d;
            act_q      <= act_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            key_q      <= key_d;
            granted_q  <= granted_d;
        end
    end

    assign grant_in_read_en_o   = pop_q;
    assign grant_out_write_en_o = push_q;
    assign grant_out_data_o     = data_q;
    assign active_count_o       = act_q;
    assign drop_count_o         = drop_q;

endmodule

// File: tb/tb_srpt_grant_sched.sv
// Directed testbench for srpt_grant_sched with hand-computed expectations.
module tb_srpt_grant_sched;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_ce;
    logic        grant_in_empty_i;
    logic        grant_in_read_en_o;
    logic [50:0] grant_in_data_i;
    logic        grant_out_full_i;
    logic        grant_out_write_en_o;
    logic [40:0] grant_out_data_o;
    logic [3:0]  active_count_o;
    logic [15:0] drop_count_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rd_cyc = 0;
    int wr_n   = 0;
    int          wr_cyc  [0:63];
    logic [40:0] wr_data [0:63];

    localparam logic [2:0] P_BLOCK  = 3'b001;
    localparam logic [2:0] P_ACTIVE = 3'b110;

    srpt_grant_sched dut (
        .ap_clk               (ap_clk),
        .ap_rst               (ap_rst),
        .ap_ce                (ap_ce),
        .grant_in_empty_i     (grant_in_empty_i),
        .grant_in_read_en_o   (grant_in_read_en_o),
        .grant_in_data_i      (grant_in_data_i),
        .grant_out_full_i     (grant_out_full_i),
        .grant_out_write_en_o (grant_out_write_en_o),
        .grant_out_data_o     (grant_out_data_o),
        .active_count_o       (active_count_o),
        .drop_count_o         (drop_count_o)
    );

    always #5 ap_clk = ~ap_clk;

    // Cycle counter and output-FIFO monitor, sampled 1ns after each rising edge
    always @(posedge ap_clk) begin
        #1;
        cyc = cyc + 1;
        if (grant_out_write_en_o && wr_n < 64) begin
            wr_cyc[wr_n]  = cyc;
            wr_data[wr_n] = grant_out_data_o;
            wr_n = wr_n + 1;
        end
    end

    function automatic logic [50:0] mk_entry(input int peer, input int rpc,
                                             input int recv, input int gnt,
                                             input logic [2:0] prio);
        return {14'(peer), 14'(rpc), 10'(recv), 10'(gnt), prio};
    endfunction

    function automatic logic [40:0] mk_grant(input int peer, input int rpc,
                                             input int off, input int idx);
        return {14'(peer), 14'(rpc), 10'(off), 3'(idx)};
    endfunction

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    // Offer one entry and return on the negedge where the pop strobe is seen
    task automatic push(input logic [50:0] e);
        int t;
        t = 0;
        grant_in_data_i  = e;
        grant_in_empty_i = 1'b0;
        do begin
            @(negedge ap_clk);
            t++;
        end while (!grant_in_read_en_o && t < 60);
        grant_in_empty_i = 1'b1;
        rd_cyc = cyc;
        checks++;
        if (!grant_in_read_en_o) begin
            errors++;
            $display("FAIL pop_timeout: read_en=%0b after %0d cycles, required 1", grant_in_read_en_o, t);
        end
    endtask

    // Wait up to budget cycles for a write beyond index start_n
    task automatic wait_write(input int start_n, input int budget, output logic got);
        int t;
        t = 0;
        while (wr_n <= start_n && t < budget) begin
            @(negedge ap_clk);
            t++;
        end
        got = (wr_n > start_n);
    endtask

    task automatic test_reset();
        ap_ce = 1'b1;
        grant_in_empty_i = 1'b1;
        grant_in_data_i  = '0;
        grant_out_full_i = 1'b0;
        do_reset();
        checks++;
        if (grant_in_read_en_o !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %0b required 0", grant_in_read_en_o); end
        checks++;
        if (grant_out_write_en_o !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %0b required 0", grant_out_write_en_o); end
        checks++;
        if (grant_out_data_o !== 41'd0) begin errors++; $display("FAIL reset_data: got %h required 0", grant_out_data_o); end
        checks++;
        if (active_count_o !== 4'd0) begin errors++; $display("FAIL reset_active: got %0d required 0", active_count_o); end
        checks++;
        if (drop_count_o !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_count_o); end
    endtask

    task automatic test_new_active();
        int n;
        logic got;
        n = wr_n;
        push(mk_entry(5, 9, 1, 20, P_ACTIVE));
        wait_write(n, 10, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL new_active_write: no write seen, required one");
        end else begin
            checks++;
            if (wr_data[n] !== mk_grant(5, 9, 9, 0)) begin errors++; $display("FAIL new_active_data: got %h required %h", wr_data[n], mk_grant(5, 9, 9, 0)); end
            checks++;
            if (wr_cyc[n] - rd_cyc != 2) begin errors++; $display("FAIL new_active_latency: got %0d required 2", wr_cyc[n] - rd_cyc); end
        end
        checks++;
        if (active_count_o !== 4'd1) begin errors++; $display("FAIL new_active_count: got %0d required 1", active_count_o); end
    endtask

    task automatic test_update();
        int n;
        logic got;
        n = wr_n;
        push(mk_entry(5, 9, 3, 2, P_ACTIVE));
        wait_write(n, 10, got);
        checks++;
        if (got) begin errors++; $display("FAIL update_nogrow: write %h seen, required none", wr_data[n]); end
        n = wr_n;
        push(mk_entry(5, 9, 10, 12, P_ACTIVE));
        wait_write(n, 10, got);
        checks++;
        if (!got || wr_data[n] !== mk_grant(5, 9, 18, 0)) begin
            errors++; $display("FAIL update_grow: got=%0b data %h required %h", got, wr_data[n], mk_grant(5, 9, 18, 0));
        end
        checks++;
        if (active_count_o !== 4'd1) begin errors++; $display("FAIL update_count: got %0d required 1", active_count_o); end
    endtask

    task automatic test_overcommit();
        int n;
        logic got;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            n = wr_n;
            push(mk_entry(1, 100 + i, 0, 1, P_ACTIVE));
            wait_write(n, 10, got);
            checks++;
            if (!got || wr_data[n] !== mk_grant(1, 100 + i, 1, i)) begin
                errors++; $display("FAIL fill_slot_%0d: got=%0b data %h required %h", i, got, wr_data[n], mk_grant(1, 100 + i, 1, i));
            end
        end
        checks++;
        if (active_count_o !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d required 8", active_count_o); end
        n = wr_n;
        push(mk_entry(1, 108, 0, 1, P_ACTIVE));
        wait_write(n, 10, got);
        checks++;
        if (got) begin errors++; $display("FAIL ninth_nowrite: write %h seen, required none", wr_data[n]); end
        checks++;
        if (drop_count_o !== 16'd1) begin errors++; $display("FAIL ninth_drop: got %0d required 1", drop_count_o); end
        push(mk_entry(1, 103, 0, 0, P_BLOCK));
        repeat (2) @(negedge ap_clk);
        checks++;
        if (active_count_o !== 4'd7) begin errors++; $display("FAIL block_count: got %0d required 7", active_count_o); end
        n = wr_n;
        push(mk_entry(1, 200, 0, 4, P_ACTIVE));
        wait_write(n, 10, got);
        checks++;
        if (!got || wr_data[n] !== mk_grant(1, 200, 4, 3)) begin
            errors++; $display("FAIL reuse_block_slot: got=%0b data %h required %h", got, wr_data[n], mk_grant(1, 200, 4, 3));
        end
        n = wr_n;
        push(mk_entry(1, 100, 5, 0, P_ACTIVE));
        wait_write(n, 10, got);
        checks++;
        if (got) begin errors++; $display("FAIL free_nowrite: write %h seen, required none", wr_data[n]); end
        checks++;
        if (active_count_o !== 4'd7) begin errors++; $display("FAIL free_count: got %0d required 7", active_count_o); end
        push(mk_entry(1, 999, 0, 0, P_BLOCK));
        repeat (2) @(negedge ap_clk);
        checks++;
        if (active_count_o !== 4'd7) begin errors++; $display("FAIL block_miss_count: got %0d required 7", active_count_o); end
        n = wr_n;
        push(mk_entry(1, 201, 2, 3, P_ACTIVE));
        wait_write(n, 10, got);
        checks++;
        if (!got || wr_data[n] !== mk_grant(1, 201, 5, 0)) begin
            errors++; $display("FAIL reuse_free_slot: got=%0b data %h required %h", got, wr_data[n], mk_grant(1, 201, 5, 0));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic got;
        do_reset();
        n = wr_n;
        push(mk_entry(2, 1, 0, 3, P_ACTIVE));
        push(mk_entry(2, 2, 5, 8, P_ACTIVE));
        wait_write(n + 1, 20, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL b2b_writes: %0d writes seen, required 2", wr_n - n);
        end else begin
            checks++;
            if (wr_data[n] !== mk_grant(2, 1, 3, 0) || wr_data[n+1] !== mk_grant(2, 2, 13, 1)) begin
                errors++; $display("FAIL b2b_data: got %h %h required %h %h", wr_data[n], wr_data[n+1], mk_grant(2, 1, 3, 0), mk_grant(2, 2, 13, 1));
            end
            checks++;
            if (wr_cyc[n+1] - wr_cyc[n] != 7) begin errors++; $display("FAIL b2b_spacing: got %0d required 7", wr_cyc[n+1] - wr_cyc[n]); end
        end
    endtask

    task automatic test_stall();
        int n;
        logic got;
        logic [40:0] held;
        held = grant_out_data_o;
        n = wr_n;
        grant_out_full_i = 1'b1;
        push(mk_entry(3, 3, 1020, 8, P_ACTIVE));
        for (int i = 1; i <= 6; i++) begin
            @(negedge ap_clk);
            checks++;
            if (grant_out_write_en_o !== 1'b0 || grant_out_data_o !== held) begin
                errors++; $display("FAIL stall_hold_%0d: we=%0b data %h required we=0 data %h", i, grant_out_write_en_o, grant_out_data_o, held);
            end
        end
        grant_out_full_i = 1'b0;
        wait_write(n, 10, got);
        checks++;
        if (!got || wr_data[n] !== mk_grant(3, 3, 1023, 2)) begin
            errors++; $display("FAIL stall_data: got=%0b data %h required %h", got, wr_data[n], mk_grant(3, 3, 1023, 2));
        end
        checks++;
        if (got && wr_cyc[n] - rd_cyc != 7) begin errors++; $display("FAIL stall_latency: got %0d required 7", wr_cyc[n] - rd_cyc); end
    endtask

    task automatic test_ce();
        int n;
        logic got;
        n = wr_n;
        push(mk_entry(4, 4, 0, 8, P_ACTIVE));
        ap_ce = 1'b0;
        repeat (3) @(negedge ap_clk);
        checks++;
        if (wr_n != n || grant_in_read_en_o !== 1'b0) begin
            errors++; $display("FAIL ce_hold: writes %0d read_en %0b required 0 0", wr_n - n, grant_in_read_en_o);
        end
        ap_ce = 1'b1;
        wait_write(n, 10, got);
        checks++;
        if (!got || wr_data[n] !== mk_grant(4, 4, 8, 3)) begin
            errors++; $display("FAIL ce_resume: got=%0b data %h required %h", got, wr_data[n], mk_grant(4, 4, 8, 3));
        end
        checks++;
        if (got && wr_cyc[n] - rd_cyc != 5) begin errors++; $display("FAIL ce_latency: got %0d required 5", wr_cyc[n] - rd_cyc); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic got;
        n = wr_n;
        push(mk_entry(6, 6, 0, 8, P_ACTIVE));
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        checks++;
        if (grant_in_read_en_o !== 1'b0 || grant_out_write_en_o !== 1'b0) begin
            errors++; $display("FAIL midrst_strobes: read_en %0b write_en %0b required 0 0", grant_in_read_en_o, grant_out_write_en_o);
        end
        wait_write(n, 10, got);
        checks++;
        if (got) begin errors++; $display("FAIL midrst_nowrite: write %h seen, required none", wr_data[n]); end
        checks++;
        if (active_count_o !== 4'd0) begin errors++; $display("FAIL midrst_count: got %0d required 0", active_count_o); end
        n = wr_n;
        push(mk_entry(7, 7, 0, 2, P_ACTIVE));
        wait_write(n, 10, got);
        checks++;
        if (!got || wr_data[n] !== mk_grant(7, 7, 2, 0)) begin
            errors++; $display("FAIL midrst_realloc: got=%0b data %h required %h", got, wr_data[n], mk_grant(7, 7, 2, 0));
        end
    endtask

    initial begin
        ap_rst = 1'b1;
        ap_ce  = 1'b1;
        grant_in_empty_i = 1'b1;
        grant_in_data_i  = '0;
        grant_out_full_i = 1'b0;
        test_reset();
        test_new_active();
        repeat (6) @(negedge ap_clk);
        test_update();
        test_overcommit();
        test_back_to_back();
        test_stall();
        test_ce();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
